// File: rtl/store_buffer_unit.sv
// Store buffer: formats SB/SH/SW/SD stores, rejects misaligned ones, queues legal stores and
// drains them to dmem over req/ack. Define STORE_BUF_FWD_EN to enable store-to-load forwarding.
module store_buffer_unit #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                       ms_riscv32_mp_clk_in,
    input  logic                       ms_riscv32_mp_rst_in,
    input  logic                       st_valid_in,
    output logic                       st_ready_out,
    input  logic [2:0]                 funct3_in,
    input  logic [ADDR_W-1:0]          iadder_in,
    input  logic [XLEN-1:0]            rs2_in,
    output logic                       misaligned_out,
    output logic [$clog2(DEPTH):0]     sb_count_out,
    output logic                       ms_riscv32_mp_dmwr_req_out,
    output logic [ADDR_W-1:0]          ms_riscv32_mp_dmaddr_out,
    output logic [XLEN-1:0]            ms_riscv32_mp_dmdata_out,
    output logic [XLEN/8-1:0]          ms_riscv32_mp_dmwr_mask_out,
    input  logic                       ms_riscv32_mp_dmwr_ack_in,
    input  logic [ADDR_W-1:0]          ld_addr_in,
    output logic                       ld_hit_out,
    output logic [XLEN-1:0]            ld_data_out,
    output logic [XLEN/8-1:0]          ld_mask_out
);

    localparam int MW    = XLEN / 8;
    localparam int OFF_W = $clog2(MW);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t             state, state_next;
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               misalign_p1;

    logic [ADDR_W-1:0]  mem_addr [DEPTH];
    logic [XLEN-1:0]    mem_data [DEPTH];
    logic [MW-1:0]      mem_mask [DEPTH];

    logic [OFF_W-1:0]   off;
    logic [ADDR_W-1:0]  fmt_addr;
    logic [XLEN-1:0]    fmt_data;
    logic [MW-1:0]      fmt_mask;
    logic               fmt_legal;
    logic               push, pop, req;

    // Stage 0: format the incoming store into aligned address / lane-replicated data / mask
    always_comb begin
        off       = iadder_in[OFF_W-1:0];
        fmt_addr  = {iadder_in[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        fmt_data  = '0;
        fmt_mask  = '0;
        fmt_legal = 1'b0;
        case (funct3_in)
            3'b000: begin
                fmt_legal = 1'b1;
                fmt_data  = {MW{rs2_in[7:0]}};
                fmt_mask  = MW'(1) << off;
            end
            3'b001: begin
                fmt_legal = !off[0];
                fmt_data  = {(MW/2){rs2_in[15:0]}};
                fmt_mask  = MW'(2'b11) << off;
            end
            3'b010: begin
                fmt_legal = (off[1:0] == 2'b00);
                fmt_data  = {(XLEN/32){rs2_in[31:0]}};
                fmt_mask  = MW'(4'hF) << off;
            end
            3'b011: begin
                // Doubleword stores only exist on the 64-bit build
                fmt_legal = (XLEN == 64) && (off == '0);
                fmt_data  = rs2_in;
                fmt_mask  = '1;
            end
            default: fmt_legal = 1'b0;
        endcase
    end

    assign st_ready_out = (count != CNT_W'(DEPTH));
    assign req          = (state == BUSY);
    assign push         = st_valid_in & st_ready_out & fmt_legal;
    assign pop          = req & ms_riscv32_mp_dmwr_ack_in;

    // Stage 1: FIFO storage (data only, no reset)
    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (push) begin
            mem_addr[wr_ptr] <= fmt_addr;
            mem_data[wr_ptr] <= fmt_data;
            mem_mask[wr_ptr] <= fmt_mask;
        end
    end

    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
        if (!ms_riscv32_mp_rst_in) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            misalign_p1 <= 1'b0;
        end else begin
            state       <= state_next;
            misalign_p1 <= st_valid_in & st_ready_out & !fmt_legal;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + CNT_W'(1);
            else if (pop && !push) count <= count - CNT_W'(1);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (push) state_next = BUSY;
            BUSY: if (pop && !push && count == CNT_W'(1)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Stage 2: dmem port presents the head entry while a request is outstanding
    assign ms_riscv32_mp_dmwr_req_out  = req;
    assign ms_riscv32_mp_dmaddr_out    = req ? mem_addr[rd_ptr] : '0;
    assign ms_riscv32_mp_dmdata_out    = req ? mem_data[rd_ptr] : '0;
    assign ms_riscv32_mp_dmwr_mask_out = req ? mem_mask[rd_ptr] : '0;
    assign misaligned_out              = misalign_p1;
    assign sb_count_out                = count;

`ifdef STORE_BUF_FWD_EN
    logic [ADDR_W-1:0] ld_aligned;
    logic [PTR_W-1:0]  fwd_idx;
    logic              unused_ld_off;

    assign unused_ld_off = ^ld_addr_in[OFF_W-1:0];

    // Scan oldest to youngest so the youngest matching entry overrides older ones
    always_comb begin
        ld_aligned  = {ld_addr_in[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        fwd_idx     = '0;
        ld_hit_out  = 1'b0;
        ld_data_out = '0;
        ld_mask_out = '0;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = rd_ptr + PTR_W'(i);
            if ((CNT_W'(i) < count) && (mem_addr[fwd_idx] == ld_aligned)) begin
                ld_hit_out  = 1'b1;
                ld_data_out = mem_data[fwd_idx];
                ld_mask_out = mem_mask[fwd_idx];
            end
        end
    end
`else
    logic unused_ld_addr;

    assign unused_ld_addr = ^ld_addr_in;
    assign ld_hit_out     = 1'b0;
    assign ld_data_out    = '0;
    assign ld_mask_out    = '0;
`endif

endmodule
